// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 device-to-host receiver; synchronises and glitch-filters the pins,
// deserialises 11-bit frames and strobes out validated bytes or a frame error.
module ps2_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic       Clock,
    input  logic       nReset,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic [7:0] data,
    output logic       data_en,
    output logic       frame_err,
    output logic       busy
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t          state;
    logic [1:0]      clk_sync, dat_sync;
    logic            clk_filt, clk_filt_d, fe, dat;
    logic [FW-1:0]   filt_cnt;
    logic [TW-1:0]   to_cnt;
    logic [2:0]      bit_cnt;
    logic [7:0]      shift;
    logic            par;

    assign fe   = clk_filt_d & ~clk_filt;
    assign dat  = dat_sync[1];
    assign busy = state != IDLE;

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            clk_sync   <= 2'b11;
            dat_sync   <= 2'b11;
            clk_filt   <= 1'b1;
            clk_filt_d <= 1'b1;
            filt_cnt   <= '0;
        end else begin
            clk_sync   <= {clk_sync[0], PS2_CLK};
            dat_sync   <= {dat_sync[0], PS2_DAT};
            clk_filt_d <= clk_filt;
            // the level only flips after an unbroken run of differing samples
            if (clk_sync[1] == clk_filt)
                filt_cnt <= '0;
            else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                clk_filt <= clk_sync[1];
                filt_cnt <= '0;
            end else
                filt_cnt <= filt_cnt + 1'b1;
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state     <= IDLE;
            data      <= 8'h00;
            data_en   <= 1'b0;
            frame_err <= 1'b0;
            to_cnt    <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            par       <= 1'b0;
        end else begin
            data_en   <= 1'b0;
            frame_err <= 1'b0;
            // an fe landing on the terminal count keeps the frame alive
            if (state != IDLE && !fe && to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                state     <= IDLE;
                frame_err <= 1'b1;
                to_cnt    <= '0;
            end else begin
                to_cnt <= (fe || state == IDLE) ? '0 : to_cnt + 1'b1;
                if (fe) begin
                    case (state)
                        IDLE: if (!dat) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                        DATA: begin
                            shift[bit_cnt] <= dat;
                            bit_cnt        <= bit_cnt + 1'b1;
                            if (bit_cnt == 3'd7) state <= PARITY;
                        end
                        PARITY: begin
                            par   <= dat;
                            state <= STOP;
                        end
                        STOP: begin
                            state <= IDLE;
                            if (dat && ^{shift, par}) begin
                                data    <= shift;
                                data_en <= 1'b1;
                            end else
                                frame_err <= 1'b1;
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_ps2_rx.sv
// tb_ps2_rx: drives PS/2 frames (directed and random) into ps2_rx and checks the
// strobes against a frame-level model of what each frame must produce.
module tb_ps2_rx;
    localparam int FL = 8;
    localparam int TO = 400;
    localparam int H  = 40;

    logic       Clock = 0, nReset = 0, PS2_CLK = 1, PS2_DAT = 1;
    logic [7:0] data;
    logic       data_en, frame_err, busy;

    int total = 0, bad = 0, cyc = 0, en_cnt = 0, err_cnt = 0, last_fall = 0;
    bit         exp_err[$];
    logic [7:0] exp_val[$];
    logic [7:0] model_data = 8'h00;
    bit         e;
    logic [7:0] v;

    ps2_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
        .Clock(Clock), .nReset(nReset), .PS2_CLK(PS2_CLK), .PS2_DAT(PS2_DAT),
        .data(data), .data_en(data_en), .frame_err(frame_err), .busy(busy)
    );

    always #10 Clock = ~Clock;
    always @(posedge Clock) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    always @(negedge Clock) begin
        if (!nReset) model_data = 8'h00;
        else begin
            chk("exclusive", data_en & frame_err, 0);
            if (data_en) en_cnt++;
            if (frame_err) err_cnt++;
            if (data_en || frame_err) begin
                if (exp_err.size() == 0) chk("unexpected_strobe", {frame_err, data_en}, 0);
                else begin
                    e = exp_err.pop_front();
                    v = exp_val.pop_front();
                    chk("strobe_kind", frame_err, e);
                    if (!e) begin
                        chk("data_val", data, v);
                        model_data = v;
                    end
                end
            end
            chk("data_hold", data, model_data);
        end
    end

    task automatic drive_bits(input logic [10:0] bits, input int n, input int glitch_at);
        for (int i = 0; i < n; i++) begin
            PS2_DAT = bits[i];
            wait_cyc(H / 2);
            if (i == glitch_at) begin
                PS2_CLK = 0;
                wait_cyc(3);
                PS2_CLK = 1;
                wait_cyc(H / 4);
            end
            PS2_CLK   = 0;
            last_fall = cyc;
            wait_cyc(H);
            PS2_CLK = 1;
            wait_cyc(H / 2);
        end
        PS2_DAT = 1;
    endtask

    // a frame is good only with stop=1 and an odd count of ones over byte+parity
    task automatic send(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int glitch_at);
        logic p, stop;
        p    = ~(^b) ^ bad_par;
        stop = ~bad_stop;
        exp_err.push_back(!(stop && ($countones(b) + int'(p)) % 2 == 1));
        exp_val.push_back(b);
        drive_bits({stop, p, b, 1'b0}, 11, glitch_at);
    endtask

    initial begin
        int k;
        wait_cyc(3);
        chk("rst_data", data, 8'h00);
        chk("rst_en", data_en, 0);
        chk("rst_err", frame_err, 0);
        chk("rst_busy", busy, 0);
        nReset = 1;
        wait_cyc(5);

        send(8'h16, 0, 0, -1);
        chk("f1_data", data, 8'h16);
        chk("f1_busy", busy, 0);
        chk("f1_en_cnt", en_cnt, 1);
        chk("f1_err_cnt", err_cnt, 0);

        send(8'hF0, 0, 0, -1);
        send(8'h16, 0, 0, -1);
        chk("b2b_en_cnt", en_cnt, 3);
        chk("b2b_data", data, 8'h16);

        send(8'h1E, 1, 0, -1);
        chk("par_err_cnt", err_cnt, 1);
        chk("par_data", data, 8'h16);
        send(8'h45, 0, 1, -1);
        chk("stop_err_cnt", err_cnt, 2);
        chk("stop_en_cnt", en_cnt, 3);

        exp_err.push_back(1);
        exp_val.push_back(8'h00);
        drive_bits(11'b0, 5, -1);
        chk("to_busy_mid", busy, 1);
        k = 0;
        while (!frame_err && k < TO + 100) begin
            @(negedge Clock);
            k++;
        end
        chk("timeout_seen", frame_err, 1);
        chk("timeout_late_enough", (cyc - last_fall) >= TO, 1);
        chk("timeout_not_too_late", (cyc - last_fall) <= TO + FL + 6, 1);
        wait_cyc(2);
        chk("to_busy_after", busy, 0);
        send(8'h45, 0, 0, -1);
        chk("after_to_data", data, 8'h45);

        PS2_CLK = 0;
        wait_cyc(3);
        PS2_CLK = 1;
        wait_cyc(20);
        chk("glitch_idle_busy", busy, 0);
        send(8'h3C, 0, 0, 4);
        chk("glitch_mid_data", data, 8'h3C);

        drive_bits({2'b11, 8'hA5, 1'b0}, 6, -1);
        nReset = 0;
        wait_cyc(3);
        chk("mid_rst_data", data, 8'h00);
        chk("mid_rst_busy", busy, 0);
        nReset = 1;
        wait_cyc(5);
        send(8'h26, 0, 0, -1);
        chk("post_rst_data", data, 8'h26);

        for (int i = 0; i < 25; i++) begin
            send(8'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 5) == 0 ? int'($urandom_range(0, 10)) : -1);
            if ($urandom_range(0, 1) == 1) wait_cyc($urandom_range(0, 60));
        end

        wait_cyc(50);
        chk("all_events_seen", exp_err.size(), 0);
        chk("end_busy", busy, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ps2_rx.md
Name: ps2_rx

Overview:
- PS/2 device-to-host receiver. Deserialises keyboard frames from the PS2_CLK/PS2_DAT pins into bytes.
- Presents each validated scan-code byte (make codes, 8'hF0 break prefix, etc.) on a data / data_en strobe interface.
- Drives the keypad-entry consumers (loop count, step entry) directly. It is the producer end of their data/data_en input.

Parameters:
- FILTER_LEN, 8: consecutive identical synchronised samples required before the filtered PS2_CLK level changes.
- TIMEOUT_CYCLES, 5000: Clock cycles without a filtered PS2_CLK falling edge, mid-frame, before the frame is abandoned (100 us at 50 MHz).

Ports:
- Clock      input   1  system clock (50 MHz)
- nReset     input   1  asynchronous active-low reset
- PS2_CLK    input   1  PS/2 clock line, asynchronous, idle high
- PS2_DAT    input   1  PS/2 data line, asynchronous, idle high
- data       output  8  last validated received byte
- data_en    output  1  one-cycle pulse: data holds a new valid byte
- frame_err  output  1  one-cycle pulse: frame rejected (parity, stop or timeout)
- busy       output  1  high while a frame is in progress (state != IDLE)

Behaviour:
- Reset (async, nReset low): data=8'h00, data_en=0, frame_err=0, busy=0, state=IDLE.
- Reset also clears: both synchronisers to 1, filtered clock to 1, bit counter, shift register, timeout counter.
- Synchronisation: PS2_CLK and PS2_DAT each pass through a 2-FF synchroniser.
- Glitch filter:
  - Filtered clock changes level only after FILTER_LEN consecutive synchronised samples differ from its current level.
  - Any shorter excursion is ignored.
- Falling edge ("fe"): single-cycle event when the filtered clock goes 1->0. The synchronised PS2_DAT is sampled in that cycle.
- Frame format: start(0), d0..d7 LSB first, parity (odd over d0..d7 and parity bit), stop(1). 11 fe events total.
- States: IDLE, DATA, PARITY, STOP.
  - IDLE: on fe with DAT=0 -> DATA; clear bit counter and timeout counter. On fe with DAT=1 -> stay in IDLE, no error (spurious edge).
  - DATA: on each fe, shift DAT into bit[count] and increment the 3-bit counter. After the 8th bit (count was 7) -> PARITY.
  - PARITY: on fe, capture the parity bit -> STOP.
  - STOP: on fe, evaluate the frame and return to IDLE.
    - Valid when stop=1 AND (^{byte,parity})==1: data<=byte and data_en=1 for exactly one cycle.
    - Otherwise: frame_err=1 for one cycle and data is held unchanged.
- Latency: data_en/frame_err assert in the cycle after the fe that sampled the stop bit. Pin to strobe is 2 sync + FILTER_LEN filter + 1 cycles after the pin edge, deterministic.
- Timeout:
  - In any state other than IDLE, a counter increments each cycle and clears on fe.
  - When it reaches TIMEOUT_CYCLES-1 without an fe: state -> IDLE, frame_err pulses once, data is unchanged.
  - If an fe coincides with the terminal count, the fe wins (no timeout).
- data_en and frame_err are never high in the same cycle. Both are registered outputs.
- data holds its value indefinitely between strobes. Consumers may read it only in the data_en cycle or later.
- busy is combinational from the state register: busy = (state != IDLE).
- Reset mid-frame: all state is discarded immediately. No strobe is emitted for the partial frame. The next start bit after release is received normally.
- Back-to-back frames: the start bit may arrive on the fe immediately after the stop fe. IDLE accepts it with no gap requirement.
- The block has no transmit path. PS2_CLK/PS2_DAT are inputs only.

Test Plan:
- Send 8'h16 (parity 0, stop 1) at 12.5 kHz PS/2 clock -> exactly one data_en pulse, data=8'h16, frame_err never high, busy low afterwards.
- Send 8'hF0 (parity 1) immediately followed by 8'h16 (parity 0) -> two data_en pulses in order with data=8'hF0 then 8'h16, no frame_err.
- Send 8'h1E with parity bit 0 (wrong) -> one frame_err pulse, no data_en, data keeps its previous value (8'h16).
- Send 8'h45 with stop bit 0 -> frame_err pulse, no data_en.
- Stop the clock after 4 data bits -> frame_err pulse TIMEOUT_CYCLES cycles after the last fe, busy falls. A following clean 8'h45 frame -> data_en with data=8'h45.
- 3-cycle low glitches on PS2_CLK in IDLE and mid-frame, plus nReset asserted mid-frame -> glitches cause no state change. Reset gives data=8'h00 and busy=0, and a subsequent 8'h26 frame is received correctly.
